// File: rtl/ssd_pkg.sv
// ssd_pkg: types and helpers shared by the 7-segment display blocks.
//   seg_t      - segment pattern {g,f,e,d,c,b,a}, active-high
//   SEG_BLANK  - all segments off
//   IDX_W(n)   - width of a digit index for an n-digit bank (at least 1 bit)
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    function automatic int IDX_W(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssdec.sv
// ssdec: hex nibble to 7-segment decoder (purely combinational).
//   nib  in   4  hex digit to show
//   en   in   1  0 forces all segments off
//   seg  out  7  segment pattern {g,f,e,d,c,b,a}, active-high
module ssdec
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       en,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (en) begin
            case (nib)
                4'h0:    seg = 7'b0111111;
                4'h1:    seg = 7'b0000110;
                4'h2:    seg = 7'b1011011;
                4'h3:    seg = 7'b1001111;
                4'h4:    seg = 7'b1100110;
                4'h5:    seg = 7'b1101101;
                4'h6:    seg = 7'b1111101;
                4'h7:    seg = 7'b0000111;
                4'h8:    seg = 7'b1111111;
                4'h9:    seg = 7'b1101111;
                4'hA:    seg = 7'b1110111;
                4'hB:    seg = 7'b1111100;
                4'hC:    seg = 7'b0111001;
                4'hD:    seg = 7'b1011110;
                4'hE:    seg = 7'b1111001;
                4'hF:    seg = 7'b1110001;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexed scanner for a 7-segment display bank.
// Holds NUM_DIGITS hex nibbles and shows one digit per CLK_DIV-cycle dwell.
// New values land only at frame boundaries, so a frame never mixes digits.
//   clk         in   1             system clock, rising edge
//   nrst        in   1             asynchronous active-low reset
//   en          in   1             scan enable; 0 blanks the display
//   load        in   1             one-cycle strobe: capture value
//   value       in   4*NUM_DIGITS  hex value (digit 0 = least significant nibble)
//   blank_lz    in   1             1 = blank leading-zero digits
//   seg         out  7             segment pattern {g,f,e,d,c,b,a}, active-high
//   dig_sel     out  NUM_DIGITS    one-hot digit enable, active-high
//   frame_done  out  1             one-cycle pulse after the last digit's dwell
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 1000
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int IW = IDX_W(NUM_DIGITS);
    localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic [TW-1:0]         tick_q, tick_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         pending_q, pending_d;
    logic [VW-1:0]         shadow_q, shadow_d;
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic                  frame_done_q, frame_done_d;

    logic       wrap, boundary, upper_zero, blank_i;
    logic [3:0] nib;
    seg_t       dec_seg;

    // Digit mux and leading-zero detect: a digit is blanked when it and every
    // more significant nibble are zero; digit 0 always shows.
    always_comb begin
        wrap       = en && (tick_q == TW'(CLK_DIV - 1));
        boundary   = wrap && (idx_q == IW'(NUM_DIGITS - 1));
        nib        = 4'h0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) nib = shadow_q[4*i +: 4];
            if ((IW'(i) >= idx_q) && (shadow_q[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
        end
        blank_i = blank_lz && (idx_q != '0) && upper_zero;
    end

    ssdec u_dec (
        .nib (nib),
        .en  (en && !blank_i),
        .seg (dec_seg)
    );

    always_comb begin
        tick_d    = tick_q;
        idx_d     = idx_q;
        pending_d = load ? value : pending_q;
        shadow_d  = shadow_q;
        if (!en) begin
            tick_d = '0;
            idx_d  = '0;
        end else if (wrap) begin
            tick_d = '0;
            idx_d  = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            tick_d = tick_q + TW'(1);
        end
        // A load coinciding with the boundary is forwarded straight to shadow.
        if (boundary) shadow_d = load ? value : pending_q;
        // seg and dig_sel both derive from idx_q, so they stay aligned.
        seg_d        = dec_seg;
        dig_sel_d    = en ? (NUM_DIGITS'(1) << idx_q) : '0;
        frame_done_d = boundary;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_q       <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            shadow_q     <= '0;
            seg_q        <= SEG_BLANK;
            dig_sel_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule
